// File: rtl/ptp_port_cmp.sv
// PTP/non-PTP packet splitter: classifies each packet by Ethertype in word2 and steers it through a 3-cycle delay line to one of two ports.
// Optional macro PTP_RX_TSTAMP_EN: overwrite word0[w_ts-1:0] with the local timer sampled when the head enters.
module ptp_port_cmp #(
    parameter int          w_pkt     = 134,
    parameter int          w_ts      = 48,
    parameter logic [15:0] PTP_ETYPE = 16'h88F7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [w_ts-1:0]  timer,
    input  logic             in_data_wr,
    input  logic [w_pkt-1:0] in_data,
    output logic             inptp_data_wr,
    output logic [w_pkt-1:0] inptp_data,
    output logic             inptp_valid_wr,
    output logic             inptp_valid,
    input  logic             inptp_ready,
    output logic             out_data_wr,
    output logic [w_pkt-1:0] out_data,
    output logic             out_valid_wr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      ptp_cnt,
    output logic [31:0]      nptp_cnt,
    output logic [31:0]      drop_cnt
);

    typedef enum logic [2:0] {IDLE, W1, W2, FWD_PTP, FWD_NPTP, DROP} state_t;
    // Per-word routing tag; PEND marks word0/word1 still waiting for the decision.
    typedef enum logic [1:0] {TG_NONE, TG_PEND, TG_PTP, TG_NPTP} tag_t;

    state_t             state_reg;
    logic               s0_wr_reg, s1_wr_reg;
    logic [w_pkt-1:0]   s0_data_reg, s1_data_reg;
    tag_t               s0_tag_reg, s1_tag_reg;
    logic               s0_last_reg, s1_last_reg;
    logic               s1_abort_reg;

    logic [1:0]         hdr;
    logic               is_head, is_tail, is_mid, is_ptp_type;
    logic [w_pkt-1:0]   in_word;
    logic               resolve_en;
    tag_t               resolve_tag;
    tag_t               s1_tag_next, out_tag, fwd_tag;

    assign hdr         = in_data[w_pkt-1 -: 2];
    assign is_head     = in_data_wr && (hdr == 2'b01);
    assign is_tail     = in_data_wr && (hdr == 2'b10);
    assign is_mid      = in_data_wr && (hdr == 2'b11);
    assign is_ptp_type = (in_data[31:16] == PTP_ETYPE);
    assign fwd_tag     = (state_reg == FWD_PTP) ? TG_PTP : TG_NPTP;

`ifdef PTP_RX_TSTAMP_EN
    always_comb begin
        in_word = in_data;
        if (is_head) begin
            in_word[w_ts-1:0] = timer;
        end
    end
`else
    logic unused_timer;
    assign unused_timer = ^timer;
    assign in_word      = in_data;
`endif

    // Any exit from W1/W2 settles the pending words: either the decision or a kill.
    always_comb begin
        resolve_en  = 1'b0;
        resolve_tag = TG_NONE;
        case (state_reg)
            W1: resolve_en = !is_mid;
            W2: begin
                resolve_en = 1'b1;
                if (is_mid) begin
                    if (is_ptp_type) begin
                        resolve_tag = inptp_ready ? TG_PTP : TG_NONE;
                    end else begin
                        resolve_tag = out_ready ? TG_NPTP : TG_NONE;
                    end
                end
            end
            default: ;
        endcase
    end

    assign s1_tag_next = (resolve_en && s0_tag_reg == TG_PEND) ? resolve_tag : s0_tag_reg;
    assign out_tag     = (resolve_en && s1_tag_reg == TG_PEND) ? resolve_tag : s1_tag_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            s0_wr_reg      <= 1'b0;
            s1_wr_reg      <= 1'b0;
            s0_data_reg    <= '0;
            s1_data_reg    <= '0;
            s0_tag_reg     <= TG_NONE;
            s1_tag_reg     <= TG_NONE;
            s0_last_reg    <= 1'b0;
            s1_last_reg    <= 1'b0;
            s1_abort_reg   <= 1'b0;
            inptp_data_wr  <= 1'b0;
            inptp_data     <= '0;
            inptp_valid_wr <= 1'b0;
            inptp_valid    <= 1'b0;
            out_data_wr    <= 1'b0;
            out_data       <= '0;
            out_valid_wr   <= 1'b0;
            out_valid      <= 1'b0;
            ptp_cnt        <= '0;
            nptp_cnt       <= '0;
            drop_cnt       <= '0;
        end else begin
            s1_wr_reg    <= s0_wr_reg;
            s1_data_reg  <= s0_data_reg;
            s1_tag_reg   <= s1_tag_next;
            s1_last_reg  <= s0_last_reg;
            s1_abort_reg <= 1'b0;
            s0_wr_reg    <= in_data_wr;
            s0_data_reg  <= in_word;
            s0_tag_reg   <= TG_NONE;
            s0_last_reg  <= 1'b0;

            inptp_data_wr  <= s1_wr_reg && (out_tag == TG_PTP);
            inptp_valid_wr <= (s1_last_reg || s1_abort_reg) && (out_tag == TG_PTP);
            inptp_valid    <= s1_last_reg && (out_tag == TG_PTP);
            if (s1_wr_reg && out_tag == TG_PTP) begin
                inptp_data <= s1_data_reg;
            end
            out_data_wr  <= s1_wr_reg && (out_tag == TG_NPTP);
            out_valid_wr <= (s1_last_reg || s1_abort_reg) && (out_tag == TG_NPTP);
            out_valid    <= s1_last_reg && (out_tag == TG_NPTP);
            if (s1_wr_reg && out_tag == TG_NPTP) begin
                out_data <= s1_data_reg;
            end

            case (state_reg)
                IDLE: begin
                    if (is_head) begin
                        state_reg  <= W1;
                        s0_tag_reg <= TG_PEND;
                    end
                end
                W1: begin
                    if (is_mid) begin
                        state_reg  <= W2;
                        s0_tag_reg <= TG_PEND;
                    end else begin
                        drop_cnt <= drop_cnt + 32'd1;
                        if (is_head) begin
                            state_reg  <= W1;
                            s0_tag_reg <= TG_PEND;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                W2: begin
                    if (is_mid) begin
                        s0_tag_reg <= resolve_tag;
                        case (resolve_tag)
                            TG_PTP:  state_reg <= FWD_PTP;
                            TG_NPTP: state_reg <= FWD_NPTP;
                            default: begin
                                state_reg <= DROP;
                                drop_cnt  <= drop_cnt + 32'd1;
                            end
                        endcase
                    end else begin
                        drop_cnt <= drop_cnt + 32'd1;
                        if (is_head) begin
                            state_reg  <= W1;
                            s0_tag_reg <= TG_PEND;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                FWD_PTP, FWD_NPTP: begin
                    s0_tag_reg <= fwd_tag;
                    if (is_head) begin
                        // Close the open packet on its own port with valid=0; the new head restarts the FSM.
                        drop_cnt     <= drop_cnt + 32'd1;
                        s1_abort_reg <= 1'b1;
                        s0_tag_reg   <= TG_PEND;
                        state_reg    <= W1;
                    end else if (is_tail) begin
                        s0_last_reg <= 1'b1;
                        state_reg   <= IDLE;
                        if (state_reg == FWD_PTP) begin
                            ptp_cnt <= ptp_cnt + 32'd1;
                        end else begin
                            nptp_cnt <= nptp_cnt + 32'd1;
                        end
                    end
                end
                DROP: begin
                    if (is_tail) begin
                        state_reg <= IDLE;
                    end else if (is_head) begin
                        state_reg  <= W1;
                        s0_tag_reg <= TG_PEND;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptp_port_cmp.sv
// Directed scoreboard bench for ptp_port_cmp: expected port beats are queued at drive time and popped by a negedge monitor.
module tb_ptp_port_cmp;
    localparam int          W      = 134;
    localparam logic [15:0] ET_PTP = 16'h88F7;
    localparam logic [15:0] ET_IP  = 16'h0800;

    logic           clk;
    logic           reset_n;
    logic [47:0]    timer;
    logic           in_data_wr;
    logic [W-1:0]   in_data;
    logic           inptp_data_wr, inptp_valid_wr, inptp_valid, inptp_ready;
    logic [W-1:0]   inptp_data;
    logic           out_data_wr, out_valid_wr, out_valid, out_ready;
    logic [W-1:0]   out_data;
    logic [31:0]    ptp_cnt, nptp_cnt, drop_cnt;

    ptp_port_cmp #(.w_pkt(W), .w_ts(48), .PTP_ETYPE(ET_PTP)) dut (
        .clk(clk), .reset(reset_n), .timer(timer),
        .in_data_wr(in_data_wr), .in_data(in_data),
        .inptp_data_wr(inptp_data_wr), .inptp_data(inptp_data),
        .inptp_valid_wr(inptp_valid_wr), .inptp_valid(inptp_valid), .inptp_ready(inptp_ready),
        .out_data_wr(out_data_wr), .out_data(out_data),
        .out_valid_wr(out_valid_wr), .out_valid(out_valid), .out_ready(out_ready),
        .ptp_cnt(ptp_cnt), .nptp_cnt(nptp_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        logic         vwr;
        logic         v;
        int           cyc;
    } exp_t;

    exp_t        q_ptp[$];
    exp_t        q_np[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ptp = 0, exp_nptp = 0, exp_drop = 0;
    int          open_port = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input string nm, input bit is_ptp, input logic dwr, input logic vwr,
                       input logic v, input logic [W-1:0] d);
        exp_t e;
        $display("%s beat cyc=%0d wr=%b vwr=%b v=%b data=%h", nm, cyc, dwr, vwr, v, d);
        if ((is_ptp && q_ptp.size() == 0) || (!is_ptp && q_np.size() == 0)) begin
            check({nm, "_unexpected"}, 256'({dwr, vwr}), 256'(0));
        end else begin
            if (is_ptp) e = q_ptp.pop_front();
            else        e = q_np.pop_front();
            check({nm, "_cycle"}, 256'(cyc), 256'(e.cyc));
            check({nm, "_data_wr"}, 256'(dwr), 256'(1));
            check({nm, "_data"}, 256'(d), 256'(e.data));
            check({nm, "_valid_wr"}, 256'(vwr), 256'(e.vwr));
            check({nm, "_valid"}, 256'(v), 256'(e.v));
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (inptp_data_wr || inptp_valid_wr)
                mon("ptp", 1'b1, inptp_data_wr, inptp_valid_wr, inptp_valid, inptp_data);
            if (out_data_wr || out_valid_wr)
                mon("nptp", 1'b0, out_data_wr, out_valid_wr, out_valid, out_data);
        end
    end

    function automatic logic [W-1:0] mk_word(input int idx, input bit tl, input logic [15:0] et);
        logic [159:0] r;
        logic [W-1:0] w;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        w = r[W-1:0];
        w[W-1 -: 2] = (idx == 0) ? 2'b01 : (tl ? 2'b10 : 2'b11);
        if (idx == 0) w[47:0] = '0;
        if (idx == 2) w[31:16] = et;
        return w;
    endfunction

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            in_data_wr = 1'b0;
            in_data    = '0;
        end
    endtask

    // n words; rdy is the selected port's ready at the decision, inverted on all other words.
    task automatic send_pkt(input int n, input logic [15:0] et, input logic rdy, input bit notail,
                            input int gap_at, input logic [47:0] ts);
        bit is_ptp;
        bit fwd;
        exp_t e;
        is_ptp = (et == ET_PTP);
        fwd    = (n >= 4) && rdy;
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] w;
            logic [W-1:0] xw;
            bit tl;
            if (i == gap_at) begin
                @(negedge clk);
                in_data_wr = 1'b0;
                in_data    = '0;
            end
            tl = (i == n - 1) && !notail;
            w  = mk_word(i, tl, et);
            @(negedge clk);
            if (i == 0) begin
                timer = ts;
                if (open_port != 0) begin
                    if (open_port == 1) begin
                        e = q_ptp.pop_back(); e.vwr = 1'b1; e.v = 1'b0; q_ptp.push_back(e);
                    end else begin
                        e = q_np.pop_back(); e.vwr = 1'b1; e.v = 1'b0; q_np.push_back(e);
                    end
                    exp_drop++;
                    open_port = 0;
                end
            end else begin
                timer = ~ts;
            end
            if (i == 2) begin
                inptp_ready = is_ptp ? rdy : 1'b1;
                out_ready   = is_ptp ? 1'b1 : rdy;
            end else begin
                inptp_ready = !rdy;
                out_ready   = !rdy;
            end
            in_data_wr = 1'b1;
            in_data    = w;
            if (fwd) begin
                xw = w;
`ifdef PTP_RX_TSTAMP_EN
                if (i == 0) xw[47:0] = ts;
`endif
                e.data = xw; e.vwr = tl; e.v = tl; e.cyc = cyc + 3;
                if (is_ptp) q_ptp.push_back(e);
                else        q_np.push_back(e);
            end
        end
        if (!fwd)         exp_drop++;
        else if (!notail) begin
            if (is_ptp) exp_ptp++;
            else        exp_nptp++;
        end else          open_port = is_ptp ? 1 : 2;
    endtask

    task automatic check_state(input string tag);
        idle(8);
        check({tag, "_ptp_cnt"}, 256'(ptp_cnt), 256'(exp_ptp));
        check({tag, "_nptp_cnt"}, 256'(nptp_cnt), 256'(exp_nptp));
        check({tag, "_drop_cnt"}, 256'(drop_cnt), 256'(exp_drop));
        check({tag, "_pending"}, 256'(q_ptp.size() + q_np.size()), 256'(0));
    endtask

    function automatic logic [47:0] rnd_ts();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    initial begin
        reset_n = 1'b0; timer = '0; in_data_wr = 1'b0; in_data = '0;
        inptp_ready = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inptp_data_wr", 256'(inptp_data_wr), 256'(0));
        check("rst_inptp_valid_wr", 256'(inptp_valid_wr), 256'(0));
        check("rst_inptp_valid", 256'(inptp_valid), 256'(0));
        check("rst_inptp_data", 256'(inptp_data), 256'(0));
        check("rst_out_data_wr", 256'(out_data_wr), 256'(0));
        check("rst_out_valid_wr", 256'(out_valid_wr), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_counters", 256'({ptp_cnt, nptp_cnt, drop_cnt}), 256'(0));
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        send_pkt(4, ET_PTP, 1'b1, 0, -1, 48'h0000_0001_2345);
        check_state("ptp4");
        send_pkt(5, ET_IP, 1'b1, 0, -1, rnd_ts());
        check_state("nptp5");
        send_pkt(4, ET_PTP, 1'b0, 0, -1, rnd_ts());
        check_state("ptp_not_ready");
        send_pkt(2, ET_PTP, 1'b1, 0, -1, rnd_ts());
        send_pkt(4, ET_PTP, 1'b1, 0, -1, rnd_ts());
        check_state("short_then_ptp");
        send_pkt(6, ET_IP, 1'b1, 0, 4, rnd_ts());
        send_pkt(5, ET_PTP, 1'b1, 0, 3, rnd_ts());
        check_state("gaps_b2b");
        send_pkt(5, ET_IP, 1'b0, 0, -1, rnd_ts());
        check_state("nptp_not_ready");
        send_pkt(5, ET_PTP, 1'b1, 1, -1, rnd_ts());
        send_pkt(4, ET_IP, 1'b1, 0, -1, rnd_ts());
        check_state("head_in_fwd");

        // Stray non-head words, then a reset that lands mid-packet.
        @(negedge clk); in_data_wr = 1'b1; in_data = mk_word(1, 0, ET_PTP);
        @(negedge clk); in_data_wr = 1'b1; in_data = mk_word(3, 1, ET_PTP);
        @(negedge clk); in_data_wr = 1'b1; in_data = mk_word(0, 0, ET_PTP);
        @(negedge clk); in_data_wr = 1'b1; in_data = mk_word(1, 0, ET_PTP);
        @(negedge clk); reset_n = 1'b0; in_data_wr = 1'b0;
        @(negedge clk);
        check("midrst_counters", 256'({ptp_cnt, nptp_cnt, drop_cnt}), 256'(0));
        exp_ptp = 0; exp_nptp = 0; exp_drop = 0;
        reset_n = 1'b1;
        @(negedge clk); in_data_wr = 1'b1; in_data = mk_word(2, 0, ET_PTP);
        @(negedge clk); in_data_wr = 1'b1; in_data = mk_word(3, 0, ET_PTP);
        @(negedge clk); in_data_wr = 1'b1; in_data = mk_word(4, 1, ET_PTP);
        check_state("mid_reset");

        @(negedge clk);
        force dut.ptp_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.ptp_cnt;
        exp_ptp = 32'hFFFF_FFFF;
        send_pkt(4, ET_PTP, 1'b1, 0, -1, rnd_ts());
        check_state("wrap");
        check("wrap_zero", 256'(ptp_cnt), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
